// File: rtl/fifo_pkg.sv
// fifo_pkg: data width, data type and statistics width shared by the FIFO and its adapters
package fifo_pkg;
   localparam int DATA_WIDTH = 8;
   typedef logic [DATA_WIDTH-1:0] data_t;
   localparam int STAT_W = 32;
endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// fifo_rd_prefetch_buf: circular prefetch storage with write/pop/clear and head/occupancy outputs
module fifo_rd_prefetch_buf #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int DEPTH      = 4,
   localparam int AW        = $clog2(DEPTH),
   localparam int CW        = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [CW-1:0]         count
);
   import fifo_pkg::*;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   assign head = mem[rd_ptr];
   // storage and pointers; clear drops occupancy but leaves stale words unread
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (wr && !pop) count <= count + CW'(1);
         else if (!wr && pop) count <= count - CW'(1);
      end
   end
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: turns the FIFO registered-read port into a valid/ready stream via credit-tracked prefetch
// Optional statistics counters enabled by defining FIFO_RD_ADAPTER_STATS_EN.
module fifo_rd_stream_adapter #(
   parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready
`ifdef FIFO_RD_ADAPTER_STATS_EN
   ,
   output logic [fifo_pkg::STAT_W-1:0] stat_xfer_cnt,
   output logic [fifo_pkg::STAT_W-1:0] stat_stall_cnt
`endif
);
   import fifo_pkg::*;
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   logic [CW-1:0] count;
   logic [CW:0]   used;
   logic          inflight;
   logic          pop;
   // credit covers buffered words plus the one already requested, so a capture never finds the buffer full
   assign used       = (CW+1)'(count) + (CW+1)'(inflight);
   assign fifo_rd_en = rst_n && !fifo_empty && !flush && (used < (CW+1)'(BUF_DEPTH));
   assign m_valid    = count != '0;
   assign pop        = m_valid && m_ready && !flush;
   // inflight marks that fifo_data_out carries a requested word this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight <= 1'b0;
      else inflight <= fifo_rd_en;
   end
   fifo_rd_prefetch_buf #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (BUF_DEPTH)
   ) u_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (flush),
      .wr     (inflight && !flush),
      .wr_data(fifo_data_out),
      .pop    (pop),
      .head   (m_data),
      .count  (count)
   );
`ifdef FIFO_RD_ADAPTER_STATS_EN
   // saturating transfer and stall counters; only reset clears them, flush does not
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_xfer_cnt  <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (pop && stat_xfer_cnt != '1) stat_xfer_cnt <= stat_xfer_cnt + STAT_W'(1);
         if (m_valid && !m_ready && stat_stall_cnt != '1) stat_stall_cnt <= stat_stall_cnt + STAT_W'(1);
      end
   end
`endif
endmodule
